// File: rtl/pkt_pipe_pkg.sv
// Shared definitions for the packet pipeline.
// Packet words are 134 bits. Bits [133:132] carry the word type
// (head/body/tail) and bits [131:0] are opaque payload.
package pkt_pipe_pkg;

    localparam int PKT_W   = 134;
    localparam int TYPE_HI = 133;
    localparam int TYPE_LO = 132;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] TAIL = 2'b10;

    typedef logic [PKT_W-1:0] pkt_word_t;

    typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_DROP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_SEND}            rd_state_t;

    function automatic logic [1:0] word_type(input pkt_word_t w);
        return w[TYPE_HI:TYPE_LO];
    endfunction

    function automatic pkt_word_t force_tail(input pkt_word_t w);
        pkt_word_t r;
        r = w;
        r[TYPE_HI:TYPE_LO] = TAIL;
        return r;
    endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Single-clock FIFO with a registered read port and an occupancy count.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears pointers/count)
//   wr_en, wr_data  write port
//   rd_en, rd_data  read port; rd_data is valid the cycle after rd_en
//   used            words currently stored (0..DEPTH)
// The caller guarantees no write when full and no read when empty.
module pkt_sync_fifo #(
    parameter  int DEPTH = 256,
    parameter  int W     = 134,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [AW:0]  used
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage and read register carry no reset so they map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

endmodule

// File: rtl/pkt_in_arbiter.sv
// Two-port store-and-forward ingress arbiter in front of the packet parser.
// Port 0 carries CPU traffic, port 1 physical-port traffic. Each port buffers
// whole packets in its own FIFO; complete packets are granted round-robin so
// the merged stream never interleaves two packets.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in0_valid, in0_data      port 0 word stream (no backpressure)
//   in1_valid, in1_data      port 1 word stream (no backpressure)
//   data_out_valid, data_out merged stream toward the parser
//   drop_cnt0, drop_cnt1     saturating per-port dropped-packet counters
module pkt_in_arbiter
    import pkt_pipe_pkg::*;
#(
    parameter int FIFO_DEPTH    = 256,
    parameter int MAX_PKT_WORDS = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [PKT_W-1:0] in0_data,
    input  logic             in1_valid,
    input  logic [PKT_W-1:0] in1_data,
    output logic             data_out_valid,
    output logic [PKT_W-1:0] data_out,
    output logic [31:0]      drop_cnt0,
    output logic [31:0]      drop_cnt1
);

    localparam int NUM_PORTS = 2;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int WCW       = $clog2(MAX_PKT_WORDS + 1);

    logic [NUM_PORTS-1:0]             in_valid;
    logic [NUM_PORTS-1:0][PKT_W-1:0]  in_data;
    logic [NUM_PORTS-1:0]             fifo_re;
    logic [NUM_PORTS-1:0][PKT_W-1:0]  fifo_rdata;
    logic [NUM_PORTS-1:0]             pkt_avail;
    logic [NUM_PORTS-1:0]             pkt_dec;
    logic [NUM_PORTS-1:0][31:0]       drop_cnt_arr;

    assign in_valid = {in1_valid, in0_valid};
    assign in_data  = {in1_data, in0_data};

    // ------------------------------------------------------------------
    // Per-port write side: admission FSM, FIFO, packet and drop counters
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        wr_state_t       wr_state, wr_state_nxt;
        logic [WCW-1:0]  wcnt, wcnt_nxt;
        logic [CW-1:0]   used, free, pkt_cnt;
        logic            we, pkt_inc, drop_inc;
        pkt_word_t       wdata;
        logic [31:0]     drops;
        logic [1:0]      wtype;

        assign wtype = word_type(in_data[p]);
        assign free  = CW'(FIFO_DEPTH) - used;

        always_comb begin
            wr_state_nxt = wr_state;
            wcnt_nxt     = wcnt;
            we           = 1'b0;
            wdata        = in_data[p];
            pkt_inc      = 1'b0;
            drop_inc     = 1'b0;
            if (in_valid[p]) begin
                case (wr_state)
                    WR_IDLE: begin
                        // Reserving a maximum-size packet at head time means
                        // the FIFO can never overflow mid-packet.
                        if (wtype == HEAD) begin
                            if (free >= CW'(MAX_PKT_WORDS)) begin
                                we           = 1'b1;
                                wcnt_nxt     = WCW'(1);
                                wr_state_nxt = WR_ACCEPT;
                            end else begin
                                drop_inc     = 1'b1;
                                wr_state_nxt = WR_DROP;
                            end
                        end
                    end
                    WR_ACCEPT: begin
                        we       = 1'b1;
                        wcnt_nxt = wcnt + 1'b1;
                        if (wtype == TAIL) begin
                            pkt_inc      = 1'b1;
                            wr_state_nxt = WR_IDLE;
                        end else if (wtype == HEAD ||
                                     wcnt == WCW'(MAX_PKT_WORDS - 1)) begin
                            // Close the buffered packet with this word as its
                            // tail; whatever follows until the next tail is lost.
                            wdata        = force_tail(in_data[p]);
                            pkt_inc      = 1'b1;
                            drop_inc     = 1'b1;
                            wr_state_nxt = WR_DROP;
                        end
                    end
                    WR_DROP: begin
                        if (wtype == TAIL) wr_state_nxt = WR_IDLE;
                    end
                    default: wr_state_nxt = WR_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_state <= WR_IDLE;
                wcnt     <= '0;
                pkt_cnt  <= '0;
                drops    <= '0;
            end else begin
                wr_state <= wr_state_nxt;
                wcnt     <= wcnt_nxt;
                if (pkt_inc && !pkt_dec[p])
                    pkt_cnt <= pkt_cnt + 1'b1;
                else if (!pkt_inc && pkt_dec[p])
                    pkt_cnt <= pkt_cnt - 1'b1;
                if (drop_inc && drops != 32'hFFFF_FFFF)
                    drops <= drops + 32'd1;
            end
        end

        pkt_sync_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (PKT_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (we),
            .wr_data (wdata),
            .rd_en   (fifo_re[p]),
            .rd_data (fifo_rdata[p]),
            .used    (used)
        );

        assign pkt_avail[p]    = (pkt_cnt != '0);
        assign drop_cnt_arr[p] = drops;
    end

    assign drop_cnt0 = drop_cnt_arr[0];
    assign drop_cnt1 = drop_cnt_arr[1];

    // ------------------------------------------------------------------
    // Read side: round-robin packet grant and streaming
    // ------------------------------------------------------------------
    // rr is both the last-granted port and, while sending, the port being
    // drained.
    rd_state_t rd_state, rd_state_nxt;
    logic      rr, rr_nxt;
    pkt_word_t cur_word;

    assign cur_word = fifo_rdata[rr];

    always_comb begin
        rd_state_nxt = rd_state;
        rr_nxt       = rr;
        fifo_re      = '0;
        pkt_dec      = '0;
        case (rd_state)
            RD_IDLE: begin
                if (|pkt_avail) begin
                    rr_nxt          = (&pkt_avail) ? ~rr : pkt_avail[1];
                    fifo_re[rr_nxt] = 1'b1;
                    rd_state_nxt    = RD_SEND;
                end
            end
            RD_SEND: begin
                // cur_word is the word fetched last cycle. Stop fetching once
                // it is the tail so the next packet's head stays in the FIFO.
                if (word_type(cur_word) == TAIL) begin
                    pkt_dec[rr]  = 1'b1;
                    rd_state_nxt = RD_IDLE;
                end else begin
                    fifo_re[rr] = 1'b1;
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state       <= RD_IDLE;
            rr             <= 1'b1;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            rd_state       <= rd_state_nxt;
            rr             <= rr_nxt;
            data_out_valid <= (rd_state == RD_SEND);
            if (rd_state == RD_SEND) data_out <= cur_word;
        end
    end

endmodule
